// File: rtl/store_commit_buffer_if.sv
// rtl/store_commit_buffer_if.sv - retire, memory-write and forwarding signals of the store commit buffer
interface store_commit_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_retire_store;
    logic [ADDR_W-1:0] i_retire_addr;
    logic [DATA_W-1:0] i_retire_data;
    logic              o_sb_full;
    logic              o_sb_empty;
    logic              o_overflow;
    logic              o_mem_wr_req;
    logic [ADDR_W-1:0] o_mem_wr_addr;
    logic [DATA_W-1:0] o_mem_wr_data;
    logic              i_mem_wr_ack;
    logic [ADDR_W-1:0] i_ld_addr;
    logic              o_fwd_hit;
    logic [DATA_W-1:0] o_fwd_data;

    // Buffer side.
    modport slave (
        input  i_retire_store, i_retire_addr, i_retire_data,
        input  i_mem_wr_ack, i_ld_addr,
        output o_sb_full, o_sb_empty, o_overflow,
        output o_mem_wr_req, o_mem_wr_addr, o_mem_wr_data,
        output o_fwd_hit, o_fwd_data
    );

    // Retire logic / memory / LSU side.
    modport master (
        output i_retire_store, i_retire_addr, i_retire_data,
        output i_mem_wr_ack, i_ld_addr,
        input  o_sb_full, o_sb_empty, o_overflow,
        input  o_mem_wr_req, o_mem_wr_addr, o_mem_wr_data,
        input  o_fwd_hit, o_fwd_data
    );
endinterface

// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - post-retire store buffer with in-order drain and load forwarding (option: STORE_BUF_COALESCE_EN)
module store_commit_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    store_commit_buffer_if.slave    sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic              overflow_q;

    logic              full, pop, push_alloc, coal_push, coal_hit;
    logic [PTR_W-1:0]  coal_idx;
    logic              unused_low_bits;

    // Only word addresses matter; the byte-offset bits are deliberately ignored.
    assign unused_low_bits = ^{sb.i_ld_addr[1:0], sb.i_retire_addr[1:0]};

    assign full          = (count_q == CNT_W'(DEPTH));
    assign sb.o_sb_full  = full;
    assign sb.o_sb_empty = (count_q == '0);
    assign sb.o_overflow = overflow_q;

    assign sb.o_mem_wr_req  = (state_q == ISSUE);
    assign sb.o_mem_wr_addr = sb.o_mem_wr_req ? addr_q[head_q] : '0;
    assign sb.o_mem_wr_data = sb.o_mem_wr_req ? data_q[head_q] : '0;

    assign pop = (state_q == ISSUE) && sb.i_mem_wr_ack;

`ifdef STORE_BUF_COALESCE_EN
    // Find a valid entry at the same word address that is not currently being written to memory.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_W-1:2] == sb.i_retire_addr[ADDR_W-1:2]) &&
                !((state_q == ISSUE) && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    assign coal_push  = sb.i_retire_store && coal_hit;
    assign push_alloc = sb.i_retire_store && !coal_hit && !full;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_alloc && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push_alloc)
            count_d = count_q - CNT_W'(1);
    end

    // Entry storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (push_alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= sb.i_retire_addr;
                data_q[tail_q]  <= sb.i_retire_data;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (coal_push)
                data_q[coal_idx] <= sb.i_retire_data;
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Sticky overflow: a store that could neither allocate nor coalesce was lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            overflow_q <= 1'b0;
        else if (sb.i_retire_store && full && !coal_hit)
            overflow_q <= 1'b1;
    end

    // Drain state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Drain next-state: issue while entries remain, stay in ISSUE for back-to-back writes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   if (pop && (count_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        sb.o_fwd_hit  = 1'b0;
        sb.o_fwd_data = '0;
        idx           = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (addr_q[idx][ADDR_W-1:2] == sb.i_ld_addr[ADDR_W-1:2])) begin
                sb.o_fwd_hit  = 1'b1;
                sb.o_fwd_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - directed self-checking bench for store_commit_buffer
module tb_store_commit_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    store_commit_buffer_if #(.ADDR_W(32), .DATA_W(32)) sbif ();

    store_commit_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sb      (sbif.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sbif.i_retire_store = 1'b0;
        sbif.i_retire_addr  = '0;
        sbif.i_retire_data  = '0;
        sbif.i_mem_wr_ack   = 1'b0;
        sbif.i_ld_addr      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        step();
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        sbif.i_retire_store = 1'b1;
        sbif.i_retire_addr  = a;
        sbif.i_retire_data  = d;
        step();
        sbif.i_retire_store = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++; if (sbif.o_mem_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", sbif.o_mem_wr_req); end
        checks++; if (sbif.o_sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", sbif.o_sb_empty); end
        checks++; if (sbif.o_sb_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", sbif.o_sb_full); end
        checks++; if (sbif.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", sbif.o_overflow); end
        checks++; if (sbif.o_fwd_hit !== 1'b0 || sbif.o_fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd got=%b/%h exp=0/0", sbif.o_fwd_hit, sbif.o_fwd_data); end
        checks++; if (sbif.o_mem_wr_addr !== 32'h0 || sbif.o_mem_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_bus got=%h/%h exp=0/0", sbif.o_mem_wr_addr, sbif.o_mem_wr_data); end
        do_reset();
    endtask

    task automatic test_single();
        push(32'h100, 32'hA5A5A5A5);
        sbif.i_ld_addr = 32'h103;
        #1;
        checks++; if (sbif.o_mem_wr_req !== 1'b0) begin errors++; $display("FAIL single_req_edge1 got=%b exp=0", sbif.o_mem_wr_req); end
        checks++; if (sbif.o_sb_empty !== 1'b0) begin errors++; $display("FAIL single_empty_edge1 got=%b exp=0", sbif.o_sb_empty); end
        checks++; if (sbif.o_fwd_hit !== 1'b1 || sbif.o_fwd_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL single_fwd got=%b/%h exp=1/a5a5a5a5", sbif.o_fwd_hit, sbif.o_fwd_data); end
        step();
        checks++; if (sbif.o_mem_wr_req !== 1'b1) begin errors++; $display("FAIL single_req_edge2 got=%b exp=1", sbif.o_mem_wr_req); end
        checks++; if (sbif.o_mem_wr_addr !== 32'h100 || sbif.o_mem_wr_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL single_wr_bus got=%h/%h exp=100/a5a5a5a5", sbif.o_mem_wr_addr, sbif.o_mem_wr_data); end
        sbif.i_mem_wr_ack = 1'b1;
        step();
        sbif.i_mem_wr_ack = 1'b0;
        #1;
        checks++; if (sbif.o_mem_wr_req !== 1'b0 || sbif.o_sb_empty !== 1'b1) begin errors++; $display("FAIL single_after_ack got req=%b empty=%b exp req=0 empty=1", sbif.o_mem_wr_req, sbif.o_sb_empty); end
        checks++; if (sbif.o_fwd_hit !== 1'b0) begin errors++; $display("FAIL single_fwd_after_pop got=%b exp=0", sbif.o_fwd_hit); end
        // Ack while idle must not disturb anything.
        sbif.i_mem_wr_ack = 1'b1;
        step();
        sbif.i_mem_wr_ack = 1'b0;
        checks++; if (sbif.o_sb_empty !== 1'b1 || sbif.o_mem_wr_req !== 1'b0) begin errors++; $display("FAIL idle_ack got empty=%b req=%b exp 1/0", sbif.o_sb_empty, sbif.o_mem_wr_req); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) begin
            checks++; if (sbif.o_sb_full !== 1'b0) begin errors++; $display("FAIL fill_full_early i=%0d got=%b exp=0", i, sbif.o_sb_full); end
            push(32'h10 + 32'(4 * i), 32'hD000_0000 + 32'(i));
        end
        checks++; if (sbif.o_sb_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", sbif.o_sb_full); end
        checks++; if (sbif.o_overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_early got=%b exp=0", sbif.o_overflow); end
        push(32'h20, 32'hDEAD_BEEF);
        sbif.i_ld_addr = 32'h20;
        #1;
        checks++; if (sbif.o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", sbif.o_overflow); end
        checks++; if (sbif.o_sb_full !== 1'b1) begin errors++; $display("FAIL overflow_full got=%b exp=1", sbif.o_sb_full); end
        checks++; if (sbif.o_fwd_hit !== 1'b0) begin errors++; $display("FAIL overflow_dropped got=%b exp=0", sbif.o_fwd_hit); end
        sbif.i_ld_addr = 32'h18;
        #1;
        checks++; if (sbif.o_fwd_hit !== 1'b1 || sbif.o_fwd_data !== 32'hD000_0002) begin errors++; $display("FAIL fill_fwd got=%b/%h exp=1/d0000002", sbif.o_fwd_hit, sbif.o_fwd_data); end
    endtask

    task automatic test_back_to_back();
        sbif.i_mem_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (sbif.o_mem_wr_req !== 1'b1 || sbif.o_mem_wr_addr !== 32'h10 + 32'(4 * i) || sbif.o_mem_wr_data !== 32'hD000_0000 + 32'(i)) begin
                errors++; $display("FAIL b2b_beat%0d got req=%b addr=%h data=%h exp req=1 addr=%h", i, sbif.o_mem_wr_req, sbif.o_mem_wr_addr, sbif.o_mem_wr_data, 32'h10 + 32'(4 * i));
            end
            step();
        end
        sbif.i_mem_wr_ack = 1'b0;
        checks++; if (sbif.o_mem_wr_req !== 1'b0 || sbif.o_sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_end got req=%b empty=%b exp 0/1", sbif.o_mem_wr_req, sbif.o_sb_empty); end
        checks++; if (sbif.o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", sbif.o_overflow); end
        do_reset();
        checks++; if (sbif.o_overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared got=%b exp=0", sbif.o_overflow); end
    endtask

    task automatic test_forward();
        logic [31:0] exp_data [2];
        int          exp_n;
        int          n;
        push(32'h40, 32'h11111111);
        push(32'h40, 32'h22222222);
        sbif.i_ld_addr = 32'h42;
        #1;
        checks++; if (sbif.o_fwd_hit !== 1'b1 || sbif.o_fwd_data !== 32'h22222222) begin errors++; $display("FAIL fwd_youngest got=%b/%h exp=1/22222222", sbif.o_fwd_hit, sbif.o_fwd_data); end
        sbif.i_ld_addr = 32'h44;
        #1;
        checks++; if (sbif.o_fwd_hit !== 1'b0 || sbif.o_fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_miss got=%b/%h exp=0/0", sbif.o_fwd_hit, sbif.o_fwd_data); end
`ifdef STORE_BUF_COALESCE_EN
        exp_n = 1;
        exp_data[0] = 32'h22222222;
        exp_data[1] = 32'h0;
`else
        exp_n = 2;
        exp_data[0] = 32'h11111111;
        exp_data[1] = 32'h22222222;
`endif
        sbif.i_mem_wr_ack = 1'b1;
        n = 0;
        while (sbif.o_mem_wr_req === 1'b1 && n < 6) begin
            if (n < 2) begin
                checks++; if (sbif.o_mem_wr_addr !== 32'h40 || sbif.o_mem_wr_data !== exp_data[n]) begin errors++; $display("FAIL fwd_drain%0d got=%h/%h exp=40/%h", n, sbif.o_mem_wr_addr, sbif.o_mem_wr_data, exp_data[n]); end
            end
            n++;
            step();
        end
        sbif.i_mem_wr_ack = 1'b0;
        checks++; if (n != exp_n) begin errors++; $display("FAIL fwd_entry_count got=%0d exp=%0d", n, exp_n); end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h208; exp_addr[1] = 32'h20C; exp_addr[2] = 32'h310; exp_addr[3] = 32'h314;
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'h0000_0200 + 32'(4 * i));
        checks++; if (sbif.o_sb_full !== 1'b1 || sbif.o_mem_wr_req !== 1'b1) begin errors++; $display("FAIL pp_full got full=%b req=%b exp 1/1", sbif.o_sb_full, sbif.o_mem_wr_req); end
        // Full: push alongside a pop is still rejected.
        sbif.i_mem_wr_ack = 1'b1;
        push(32'h300, 32'h300);
        #1;
        checks++; if (sbif.o_overflow !== 1'b1 || sbif.o_sb_full !== 1'b0) begin errors++; $display("FAIL pp_full_reject got ovf=%b full=%b exp 1/0", sbif.o_overflow, sbif.o_sb_full); end
        // Count 3: push and pop together keep it at 3.
        push(32'h310, 32'h310);
        sbif.i_mem_wr_ack = 1'b0;
        #1;
        checks++; if (sbif.o_sb_full !== 1'b0 || sbif.o_sb_empty !== 1'b0) begin errors++; $display("FAIL pp_count3 got full=%b empty=%b exp 0/0", sbif.o_sb_full, sbif.o_sb_empty); end
        push(32'h314, 32'h314);
        checks++; if (sbif.o_sb_full !== 1'b1) begin errors++; $display("FAIL pp_refill got=%b exp=1", sbif.o_sb_full); end
        sbif.i_mem_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (sbif.o_mem_wr_req !== 1'b1 || sbif.o_mem_wr_addr !== exp_addr[i]) begin errors++; $display("FAIL pp_drain%0d got req=%b addr=%h exp 1/%h", i, sbif.o_mem_wr_req, sbif.o_mem_wr_addr, exp_addr[i]); end
            step();
        end
        sbif.i_mem_wr_ack = 1'b0;
        checks++; if (sbif.o_sb_empty !== 1'b1 || sbif.o_mem_wr_req !== 1'b0) begin errors++; $display("FAIL pp_end got empty=%b req=%b exp 1/0", sbif.o_sb_empty, sbif.o_mem_wr_req); end
        do_reset();
    endtask

    task automatic test_async_reset();
        push(32'h500, 32'h5555_5555);
        step();
        sbif.i_ld_addr = 32'h500;
        #1;
        checks++; if (sbif.o_mem_wr_req !== 1'b1 || sbif.o_fwd_hit !== 1'b1) begin errors++; $display("FAIL areset_pre got req=%b hit=%b exp 1/1", sbif.o_mem_wr_req, sbif.o_fwd_hit); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (sbif.o_mem_wr_req !== 1'b0 || sbif.o_sb_empty !== 1'b1 || sbif.o_sb_full !== 1'b0) begin errors++; $display("FAIL areset_state got req=%b empty=%b full=%b exp 0/1/0", sbif.o_mem_wr_req, sbif.o_sb_empty, sbif.o_sb_full); end
        checks++; if (sbif.o_fwd_hit !== 1'b0 || sbif.o_mem_wr_addr !== 32'h0 || sbif.o_mem_wr_data !== 32'h0) begin errors++; $display("FAIL areset_outputs got hit=%b addr=%h data=%h exp 0/0/0", sbif.o_fwd_hit, sbif.o_mem_wr_addr, sbif.o_mem_wr_data); end
        step();
        #2 rst_n = 1'b1;
        step();
        step();
        checks++; if (sbif.o_mem_wr_req !== 1'b0 || sbif.o_sb_empty !== 1'b1) begin errors++; $display("FAIL areset_after got req=%b empty=%b exp 0/1", sbif.o_mem_wr_req, sbif.o_sb_empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_forward();
        test_push_pop_same_cycle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Post-retire store buffer directly downstream of the reorder buffer's retire bus.
- Each store that retires from the ROB head is captured here as an architecturally committed entry, then drained in order to data memory over a req/ack handshake.
- Provides combinational store-to-load forwarding to the load/store unit and a full flag that the retire logic uses to stall store retirement.

Parameters:
DEPTH, 4, number of committed-store entries (power of two, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, store data width (word stores only)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_retire_store  input  1  retire bus: store retiring this cycle (valid & store_ready)
i_retire_addr  input  ADDR_W  retiring store byte address
i_retire_data  input  DATA_W  retiring store data
o_sb_full  output  1  count==DEPTH; retire must not assert i_retire_store
o_sb_empty  output  1  count==0
o_overflow  output  1  sticky error: push seen while full
o_mem_wr_req  output  1  write request to data memory
o_mem_wr_addr  output  ADDR_W  head entry address
o_mem_wr_data  output  DATA_W  head entry data
i_mem_wr_ack  input  1  memory accepted current request
i_ld_addr  input  ADDR_W  load lookup address
o_fwd_hit  output  1  a buffered store matches i_ld_addr
o_fwd_data  output  DATA_W  data of youngest matching entry

Behaviour:
- Storage: circular buffer, head/tail pointers $clog2(DEPTH) bits with natural wrap; count $clog2(DEPTH+1) bits.
- Reset (async, i_rst_n=0): head=tail=count=0, all entry valid bits 0, FSM=IDLE, o_mem_wr_req=0, o_overflow=0, o_sb_full=0, o_sb_empty=1, o_fwd_hit=0, o_fwd_data=0, o_mem_wr_addr/data=0. Reset mid-handshake drops the request; no write is completed.
- Push: i_retire_store=1 and !o_sb_full -> entry written at tail on the clock edge, tail+1, count+1. Push while full -> ignored, o_overflow set and held until reset.
- Entries are committed: the ROB branch-mispredict flush does not affect them (no flush port).
- Drain FSM, registered:
  - IDLE: o_mem_wr_req=0. If count!=0 at an edge -> ISSUE. A push into an empty buffer therefore raises req 2 edges later: edge 1 writes the entry, edge 2 enters ISSUE.
  - ISSUE: o_mem_wr_req=1, with addr/data driven from the head entry, stable until ack. On an edge with i_mem_wr_ack=1: pop (head+1, count-1, entry invalidated). If the post-pop count is !=0, stay in ISSUE (back-to-back, req stays high with the new head); otherwise go to IDLE.
  - i_mem_wr_ack while in IDLE is ignored.
- Simultaneous push and pop: both take effect, and count is unchanged. Full is evaluated on the pre-edge count, so no push is allowed while count==DEPTH, even during a pop cycle.
- o_sb_full and o_sb_empty are decoded from the registered count.
- Forwarding (combinational, zero latency):
  - Compare i_ld_addr[ADDR_W-1:2] against all valid entries.
  - o_fwd_hit=1 if any entry matches. o_fwd_data = data of the youngest match, i.e. nearest to tail in age order; 0 if no match.
  - The head entry under ISSUE still participates until it is popped.
  - A push in the same cycle is not visible until the next cycle.

Optional Feature:
STORE_BUF_COALESCE_EN
- Defined: a push whose word address matches a valid non-in-flight entry overwrites that entry's data. In that case pointers and count are unchanged and there is no allocation.
  - A coalescing push is accepted even when o_sb_full=1, with no overflow.
  - "In-flight" means the head entry while FSM=ISSUE; this entry is never coalesced into.
  - At most one non-in-flight entry exists per address.
- Undefined: every push allocates a new entry; duplicate addresses coexist and drain in order.

Test Plan:
- Reset then single push addr=0x100 data=0xA5A5A5A5 -> req rises 2 edges later with addr 0x100 and data 0xA5A5A5A5. Ack held 1 -> pop, req low next cycle, o_sb_empty=1.
- Push 4 stores (0x10..0x1C), with ack held 0 -> o_sb_full=1 after 4th edge. A 5th push sets o_overflow=1 and count stays 4.
- Ack held 1 continuously with 4 entries -> 4 consecutive req cycles, addresses 0x10, 0x14, 0x18, 0x1C in order, then IDLE.
- Push 0x40/0x11111111 then 0x40/0x22222222, ld_addr=0x42 -> o_fwd_hit=1, o_fwd_data=0x22222222. With STORE_BUF_COALESCE_EN, count=1 (if head not yet in ISSUE) or 2; without it, count=2.
- Full buffer, push and ack in the same cycle -> push rejected and o_overflow=1. With count=3, push and ack together -> count stays 3.
- Assert i_rst_n=0 asynchronously while req=1 -> req, count and outputs return to reset values immediately without waiting for a clock edge.
